curve25519_modaddsub: RTL

CURVE25519_MODADDSUB -- requirements
Module: curve25519_modaddsub

---
 rtl/curve25519_modaddsub_if.sv | 27 ++
 rtl/curve25519_modaddsub.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/curve25519_modaddsub_if.sv
// Start/ready handshake plus operand and result word ports of the 2^255-19 add/sub unit.
// The memory/controller side takes the master modport; the arithmetic unit takes slave.
interface curve25519_modaddsub_if #(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 8
);
   logic              start;
   logic              sub;
   logic              ready;
   logic [ADDR_W-1:0] a_addr;
   logic [WORD_W-1:0] a_data;
   logic [ADDR_W-1:0] b_addr;
   logic [WORD_W-1:0] b_data;
   logic [ADDR_W-1:0] z_addr;
   logic [WORD_W-1:0] z_data;
   logic              z_we;

   modport master (
      output start, sub, a_data, b_data,
      input  ready, a_addr, b_addr, z_addr, z_data, z_we
   );

   modport slave (
      input  start, sub, a_data, b_data,
      output ready, a_addr, b_addr, z_addr, z_data, z_we
   );
endinterface

// File: rtl/curve25519_modaddsub.sv
// Word-serial (A +/- B) mod 2^255-19: one pass forms S, one pass forms T = S -/+ p,
// then the in-range one of S/T is streamed out to the result memory.
module curve25519_modaddsub #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 256 / WORD_W,
   parameter int ADDR_W    = 8
) (
   input logic                   clk,
   input logic                   reset,
   curve25519_modaddsub_if.slave bus
);
   // state | meaning
   // IDLE  | ready=1, waiting for start
   // LOAD  | read A/B words, S = A +/- B; first cycle only covers the read latency
   // CORR  | T = S - p (add) or S + p (sub); last borrow/carry kept as c2
   // WRITE | stream selected S or T words out on z_*
   typedef enum logic [1:0] {IDLE, LOAD, CORR, WRITE} state_t;

   localparam int                IW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IW-1:0]     LAST      = IW'(NUM_WORDS - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

   state_t            state;
   logic [IW-1:0]     idx;
   logic              primed;
   logic              sub_r;
   logic              cy;
   logic              c1;
   logic              c2;
   logic [WORD_W-1:0] s_mem [NUM_WORDS];
   logic [WORD_W-1:0] t_mem [NUM_WORDS];

   logic [WORD_W-1:0] p_word;
   logic [WORD_W-1:0] s_cur;
   logic [WORD_W:0]   cy_ext;
   logic [WORD_W:0]   ld_res;
   logic [WORD_W:0]   corr_res;
   logic [IW-1:0]     idx_p1;
   logic              sel_now;
   logic              sel_wr;

   always_comb begin
      cy_ext = {{WORD_W{1'b0}}, cy};
      if (idx == '0)
         p_word = {WORD_W{1'b1}} - WORD_W'(18);
      else if (idx == LAST)
         p_word = {1'b0, {(WORD_W-1){1'b1}}};
      else
         p_word = '1;
      s_cur  = s_mem[idx];
      idx_p1 = idx + IW'(1);
      // Top bit of each WORD_W+1 result is the carry (add) or borrow (sub) out
      if (sub_r) begin
         ld_res   = {1'b0, bus.a_data} - {1'b0, bus.b_data} - cy_ext;
         corr_res = {1'b0, s_cur} + {1'b0, p_word} + cy_ext;
         sel_now  = c1;
         sel_wr   = c1;
      end else begin
         ld_res   = {1'b0, bus.a_data} + {1'b0, bus.b_data} + cy_ext;
         corr_res = {1'b0, s_cur} - {1'b0, p_word} - cy_ext;
         sel_now  = c1 | ~corr_res[WORD_W];
         sel_wr   = c1 | ~c2;
      end
   end

   // S/T scratch is never cleared: it is only read after being rewritten by a new operation
   always_ff @(posedge clk) begin
      if (state == LOAD && primed)
         s_mem[idx] <= ld_res[WORD_W-1:0];
      if (state == CORR)
         t_mem[idx] <= corr_res[WORD_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         bus.ready  <= 1'b1;
         bus.z_we   <= 1'b0;
         bus.a_addr <= '0;
         bus.b_addr <= '0;
         bus.z_addr <= '0;
         bus.z_data <= '0;
         idx        <= '0;
         primed     <= 1'b0;
         sub_r      <= 1'b0;
         cy         <= 1'b0;
         c1         <= 1'b0;
         c2         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state      <= LOAD;
                  bus.ready  <= 1'b0;
                  sub_r      <= bus.sub;
                  cy         <= 1'b0;
                  c1         <= 1'b0;
                  c2         <= 1'b0;
                  bus.a_addr <= '0;
                  bus.b_addr <= '0;
                  idx        <= '0;
                  primed     <= 1'b0;
               end
            end
            LOAD: begin
               if (bus.a_addr != LAST_ADDR) begin
                  bus.a_addr <= bus.a_addr + ADDR_W'(1);
                  bus.b_addr <= bus.a_addr + ADDR_W'(1);
               end
               primed <= 1'b1;
               if (primed) begin
                  if (idx == LAST) begin
                     c1    <= ld_res[WORD_W];
                     cy    <= 1'b0;
                     idx   <= '0;
                     state <= CORR;
                  end else begin
                     cy  <= ld_res[WORD_W];
                     idx <= idx_p1;
                  end
               end
            end
            CORR: begin
               if (idx == LAST) begin
                  // Selection must be known now so word 0 is on z_data in the first WRITE cycle
                  c2         <= corr_res[WORD_W];
                  idx        <= '0;
                  state      <= WRITE;
                  bus.z_we   <= 1'b1;
                  bus.z_addr <= '0;
                  bus.z_data <= sel_now ? t_mem[0] : s_mem[0];
               end else begin
                  cy  <= corr_res[WORD_W];
                  idx <= idx_p1;
               end
            end
            WRITE: begin
               if (idx == LAST) begin
                  bus.z_we  <= 1'b0;
                  bus.ready <= 1'b1;
                  idx       <= '0;
                  state     <= IDLE;
               end else begin
                  idx        <= idx_p1;
                  bus.z_addr <= ADDR_W'(idx_p1);
                  bus.z_data <= sel_wr ? t_mem[idx_p1] : s_mem[idx_p1];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
